// File: rtl/serial_subt_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ov signal exists only when SERIAL_SUBT_OVF_EN is defined.
interface serial_subt_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
`ifdef SERIAL_SUBT_OVF_EN
    logic             ov;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bo
`ifdef SERIAL_SUBT_OVF_EN
        , input ov
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bo
`ifdef SERIAL_SUBT_OVF_EN
        , output ov
`endif
    );
endinterface

// File: rtl/serial_subt.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one full-subtractor cell per clock.
// Define SERIAL_SUBT_OVF_EN to add the registered signed-overflow output ov.
module serial_subt #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_subt_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_q;
    logic [CW-1:0]    cnt;
    logic             brw, bo_q, busy_q, done_q;
    logic             dbit, nbrw;
`ifdef SERIAL_SUBT_OVF_EN
    logic             a_msb, b_msb, ov_q;
`endif

    // Full-subtractor cell on the current LSBs and the registered borrow.
    assign dbit = a_sr[0] ^ b_sr[0] ^ brw;
    assign nbrw = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are reset too, so an abandoned operation leaves no residue.
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            d_q    <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bo_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUBT_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ov_q   <= 1'b0;
`endif
        end else begin
            // Status flags are flops driven from the next state, keeping outputs glitch-free.
            busy_q <= (state_nxt == SHIFT);
            done_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        brw   <= bus.bin;
                        cnt   <= '0;
                        d_sr  <= '0;
`ifdef SERIAL_SUBT_OVF_EN
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= nbrw;
                    d_sr <= {dbit, d_sr[WIDTH-1:1]};
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        d_q  <= {dbit, d_sr[WIDTH-1:1]};
                        bo_q <= nbrw;
`ifdef SERIAL_SUBT_OVF_EN
                        // dbit here is the result MSB.
                        ov_q <= (a_msb != b_msb) && (dbit != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
`ifdef SERIAL_SUBT_OVF_EN
    assign bus.ov   = ov_q;
`endif
endmodule

// File: tb/tb_serial_subt.sv
// Self-checking bench for serial_subt: directed operations scored against an arithmetic model.
// Honours SERIAL_SUBT_OVF_EN when the bundle is built with it.
module tb_serial_subt;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_subt_if #(.WIDTH(W)) sif ();
    serial_subt #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        exp_t       e;
        r    = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // Present operands with start high across one edge; returns at the negedge after acceptance.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit drop_start);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        sif.bin   = bin;
        sb.push_back(model(a, b, bin));
        @(negedge clk);
        if (drop_start) sif.start = 1'b0;
    endtask

    // Counts busy cycles until done, compares against the scoreboard, then checks done fell.
    task automatic wait_done(input string tag);
        int   nbusy = 0;
        bit   seen  = 0;
        exp_t e;
        for (int i = 0; i < W + 10; i++) begin
            if (sif.busy && sif.done) check({tag, ".busy_and_done"}, 1, 0);
            if (sif.busy) nbusy++;
            if (sif.done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check({tag, ".timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, ".busy_cycles"}, nbusy, W);
        check({tag, ".d"}, 32'(sif.d), 32'(e.d));
        check({tag, ".bo"}, 32'(sif.bo), 32'(e.bo));
`ifdef SERIAL_SUBT_OVF_EN
        check({tag, ".ov"}, 32'(sif.ov), 32'(e.ov));
`endif
        @(negedge clk);
        check({tag, ".done_pulse"}, {30'd0, sif.done, sif.busy}, 0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin);
        accept(a, b, bin, 1'b1);
        wait_done(tag);
    endtask

    initial begin
        int dones;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.bin   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset.outs", {sif.busy, sif.done, sif.bo}, 0);
        check("reset.d", 32'(sif.d), 0);
`ifdef SERIAL_SUBT_OVF_EN
        check("reset.ov", 32'(sif.ov), 0);
`endif
        rst_n = 1'b1;

        run("basic",   8'h05, 8'h03, 1'b0);
        run("borrow",  8'h03, 8'h05, 1'b0);
        run("bin_00",  8'h00, 8'h00, 1'b1);
        run("bin_ff",  8'hFF, 8'hFF, 1'b1);
        run("ovf_80",  8'h80, 8'h01, 1'b0);
        run("ovf_10",  8'h10, 8'h01, 1'b0);
        for (int i = 0; i < 4; i++)
            run("rand", W'($urandom), W'($urandom), 1'($urandom));

        // start held through SHIFT and DONE with new operands: exactly one result, held ones ignored.
        accept(8'h40, 8'h22, 1'b0, 1'b0);
        sif.a   = 8'h11;
        sif.b   = 8'h99;
        sif.bin = 1'b1;
        wait_done("held");
        sif.start = 1'b0;
        @(negedge clk);
        check("held.ignored", {sif.busy, sif.done}, 0);
        check("held.d_kept", 32'(sif.d), 32'(8'h1E));
        run("held.repulse", 8'h11, 8'h99, 1'b1);

        // Reset at edge k+4 of an operation: outputs clear at once and no done follows.
        run("pre_abort", 8'h03, 8'h05, 1'b0);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 8'h77;
        sif.b     = 8'h12;
        sif.bin   = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.flags", {sif.busy, sif.done, sif.bo}, 0);
        check("abort.d", 32'(sif.d), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (sif.done || sif.busy) dones++;
        end
        check("abort.no_done", dones, 0);
        run("after_abort", 8'hA5, 8'h5A, 1'b0);

        check("scoreboard.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
